// File: rtl/cpu_alu_unit.sv
// cpu_alu_unit
// Registered integer execution unit for the Flare32 core. One operation is
// accepted per valid cycle. Its result words and updated flags appear on the
// registered outputs after the next rising clock edge.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset, clears all outputs
//   in_valid   operation issue strobe
//   oper       5-bit opcode (0-17 defined, 18-31 reserved)
//   a          operand A, also the low word for long shifts
//   a_hi       high word of A, used only by long shifts
//   b          operand B, or unsigned shift amount (full 32 bits)
//   flags_in   current flags {N,V,C,Z} in bits [3:0]
//   out_valid  result registers hold a fresh result
//   result     low result word
//   result_hi  high result word (MUL and long shifts only, else 0)
//   flags_out  updated flags, same bit order as flags_in
module cpu_alu_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [4:0]  oper,
   input  logic [31:0] a,
   input  logic [31:0] a_hi,
   input  logic [31:0] b,
   input  logic [3:0]  flags_in,
   output logic        out_valid,
   output logic [31:0] result,
   output logic [31:0] result_hi,
   output logic [3:0]  flags_out
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_ADC  = 5'd1,
      OP_SUB  = 5'd2,
      OP_SBC  = 5'd3,
      OP_RSB  = 5'd4,
      OP_MUL  = 5'd5,
      OP_AND  = 5'd6,
      OP_ORR  = 5'd7,
      OP_XOR  = 5'd8,
      OP_BIC  = 5'd9,
      OP_LSL  = 5'd10,
      OP_LSR  = 5'd11,
      OP_ASR  = 5'd12,
      OP_ROL  = 5'd13,
      OP_ROR  = 5'd14,
      OP_LLSL = 5'd15,
      OP_LLSR = 5'd16,
      OP_LASR = 5'd17
   } alu_op_e;

   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_cin;
   logic [32:0] add_sum;
   logic        add_v;

   logic [63:0] prod;
   logic [32:0] lsl_ext;
   logic [32:0] lsr_ext;
   logic [32:0] asr_ext;
   logic [4:0]  rol_amt;
   logic [31:0] rol_res;
   logic [31:0] ror_res;
   logic [63:0] long_val;
   logic [64:0] llsl_ext;
   logic [64:0] llsr_ext;
   logic [64:0] lasr_ext;

   logic [31:0] res_lo;
   logic [31:0] res_hi;
   logic        c_next;
   logic        v_next;
   logic        z_next;
   logic        n_next;
   logic        is_long;
   logic        is_reserved;
   logic [3:0]  flags_next;

   // All five add/subtract opcodes share one 33-bit adder. Subtraction is
   // expressed as addition of the inverted operand, so the carry out directly
   // means "no borrow" and overflow is judged on the operands actually added.
   always_comb begin
      add_a   = a;
      add_b   = b;
      add_cin = 1'b0;
      case (oper)
         OP_ADC: add_cin = flags_in[1];
         OP_SUB: begin
            add_b   = ~b;
            add_cin = 1'b1;
         end
         OP_SBC: begin
            add_b   = ~b;
            add_cin = flags_in[1];
         end
         OP_RSB: begin
            add_a   = b;
            add_b   = ~a;
            add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
   assign add_v   = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

   assign prod = {32'd0, a} * {32'd0, b};

   // Each shift carries one extra bit on the side where bits fall out, so the
   // last bit shifted out lands in that guard position. Shift amounts beyond
   // the width naturally yield zero (or sign fill for arithmetic shifts) in
   // both the result and the guard bit, which is exactly the carry required.
   assign lsl_ext  = {1'b0, a} << b;
   assign lsr_ext  = {a, 1'b0} >> b;
   assign asr_ext  = $signed({a, 1'b0}) >>> b;

   assign long_val = {a_hi, a};
   assign llsl_ext = {1'b0, long_val} << b;
   assign llsr_ext = {long_val, 1'b0} >> b;
   assign lasr_ext = $signed({long_val, 1'b0}) >>> b;

   // Rotates use only b[4:0]. A left rotate is a right rotate by the
   // complementary amount modulo 32, so both share the same doubled word.
   assign rol_amt = 5'd0 - b[4:0];
   assign ror_res = 32'({a[30:0], a} >> b[4:0]);
   assign rol_res = 32'({a[30:0], a} >> rol_amt);

   // Result and flag selection. C and V default to their incoming values so
   // that every opcode which leaves them alone needs no explicit assignment.
   always_comb begin
      res_lo      = 32'd0;
      res_hi      = 32'd0;
      c_next      = flags_in[1];
      v_next      = flags_in[2];
      is_long     = 1'b0;
      is_reserved = 1'b0;
      case (oper)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
            res_lo = add_sum[31:0];
            c_next = add_sum[32];
            v_next = add_v;
         end
         OP_MUL: begin
            res_lo = prod[31:0];
            res_hi = prod[63:32];
         end
         OP_AND: res_lo = a & b;
         OP_ORR: res_lo = a | b;
         OP_XOR: res_lo = a ^ b;
         OP_BIC: res_lo = a & ~b;
         OP_LSL: begin
            res_lo = lsl_ext[31:0];
            if (b != 32'd0) c_next = lsl_ext[32];
         end
         OP_LSR: begin
            res_lo = lsr_ext[32:1];
            if (b != 32'd0) c_next = lsr_ext[0];
         end
         OP_ASR: begin
            res_lo = asr_ext[32:1];
            if (b != 32'd0) c_next = asr_ext[0];
         end
         OP_ROL: begin
            res_lo = rol_res;
            if (b[4:0] != 5'd0) c_next = rol_res[0];
         end
         OP_ROR: begin
            res_lo = ror_res;
            if (b[4:0] != 5'd0) c_next = ror_res[31];
         end
         OP_LLSL: begin
            is_long          = 1'b1;
            {res_hi, res_lo} = llsl_ext[63:0];
            if (b != 32'd0) c_next = llsl_ext[64];
         end
         OP_LLSR: begin
            is_long          = 1'b1;
            {res_hi, res_lo} = llsr_ext[64:1];
            if (b != 32'd0) c_next = llsr_ext[0];
         end
         OP_LASR: begin
            is_long          = 1'b1;
            {res_hi, res_lo} = lasr_ext[64:1];
            if (b != 32'd0) c_next = lasr_ext[0];
         end
         default: is_reserved = 1'b1;
      endcase

      z_next = is_long ? ({res_hi, res_lo} == 64'd0) : (res_lo == 32'd0);
      n_next = is_long ? res_hi[31] : res_lo[31];

      // Reserved opcodes pass every incoming flag straight through.
      flags_next = is_reserved ? flags_in : {n_next, v_next, c_next, z_next};
   end

   // Output registers. An idle cycle only drops out_valid; the data and
   // flags keep the last result so the CPU can still read them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= 32'd0;
         result_hi <= 32'd0;
         flags_out <= 4'd0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         result    <= res_lo;
         result_hi <= res_hi;
         flags_out <= flags_next;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_alu_unit.sv
// tb_cpu_alu_unit
// Self-checking bench for cpu_alu_unit. A behavioural reference model
// computes each operation from plain arithmetic and tracks the registered
// outputs. One checker process compares the DUT against that model every
// cycle, and against hand-computed literals whenever a directed vector arms
// them.
module tb_cpu_alu_unit;

   localparam logic [4:0] ADD  = 5'd0,  ADC  = 5'd1,  SUB  = 5'd2,  SBC = 5'd3;
   localparam logic [4:0] RSB  = 5'd4,  MUL  = 5'd5,  ANDO = 5'd6;
   localparam logic [4:0] LSL  = 5'd10, LSR  = 5'd11, ASR  = 5'd12;
   localparam logic [4:0] ROL  = 5'd13, ROR  = 5'd14;
   localparam logic [4:0] LLSL = 5'd15, LASR = 5'd17;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [4:0]  oper;
   logic [31:0] a;
   logic [31:0] a_hi;
   logic [31:0] b;
   logic [3:0]  flags_in;
   logic        out_valid;
   logic [31:0] result;
   logic [31:0] result_hi;
   logic [3:0]  flags_out;

   // Reference model state
   logic        m_valid;
   logic [31:0] m_res;
   logic [31:0] m_hi;
   logic [3:0]  m_flags;
   logic [31:0] t_res;
   logic [31:0] t_hi;
   logic [3:0]  t_flags;

   // Armed literal expectations
   logic        lit_armed;
   string       lit_name;
   logic        lit_valid;
   logic [31:0] lit_res;
   logic [31:0] lit_hi;
   logic [3:0]  lit_flags;

   int assert_count;
   int fail_count;

   cpu_alu_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .oper      (oper),
      .a         (a),
      .a_hi      (a_hi),
      .b         (b),
      .flags_in  (flags_in),
      .out_valid (out_valid),
      .result    (result),
      .result_hi (result_hi),
      .flags_out (flags_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference computation of one operation, written directly from the
   // arithmetic meaning of each opcode.
   function automatic void model_op(input logic [4:0] op, input logic [31:0] av,
                                    input logic [31:0] ahv, input logic [31:0] bv,
                                    input logic [3:0] fin, output logic [31:0] r,
                                    output logic [31:0] rh, output logic [3:0] fo);
      logic c, v, is_long;
      logic [31:0] x, y;
      logic cin;
      logic [63:0] wide;
      longint unsigned us;
      longint ss;
      int k;
      c = fin[1]; v = fin[2]; r = 32'd0; rh = 32'd0; is_long = 1'b0;
      x = 32'd0; y = 32'd0; cin = 1'b0; wide = {ahv, av};
      if (op <= 5'd4) begin
         case (op)
            5'd0: begin x = av; y = bv;  cin = 1'b0;   end
            5'd1: begin x = av; y = bv;  cin = fin[1]; end
            5'd2: begin x = av; y = ~bv; cin = 1'b1;   end
            5'd3: begin x = av; y = ~bv; cin = fin[1]; end
            default: begin x = bv; y = ~av; cin = 1'b1; end
         endcase
         us = 64'(x) + 64'(y) + 64'(cin);
         r  = us[31:0];
         c  = (us >= 64'h1_0000_0000);
         ss = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
         v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end else begin
         case (op)
            5'd5: begin
               wide = 64'(av) * 64'(bv);
               r = wide[31:0]; rh = wide[63:32];
            end
            5'd6: r = av & bv;
            5'd7: r = av | bv;
            5'd8: r = av ^ bv;
            5'd9: r = av & ~bv;
            5'd10: begin
               if (bv == 0) r = av;
               else if (bv <= 32) begin r = av << bv; c = av[32 - bv]; end
               else begin r = 32'd0; c = 1'b0; end
            end
            5'd11: begin
               if (bv == 0) r = av;
               else if (bv <= 32) begin r = av >> bv; c = av[bv - 1]; end
               else begin r = 32'd0; c = 1'b0; end
            end
            5'd12: begin
               if (bv == 0) r = av;
               else if (bv <= 32) begin r = $signed(av) >>> bv; c = av[bv - 1]; end
               else begin r = {32{av[31]}}; c = av[31]; end
            end
            5'd13: begin
               k = int'(bv[4:0]);
               r = (av << k) | (av >> (32 - k));
               if (k != 0) c = r[0];
            end
            5'd14: begin
               k = int'(bv[4:0]);
               r = (av >> k) | (av << (32 - k));
               if (k != 0) c = r[31];
            end
            5'd15, 5'd16, 5'd17: begin
               is_long = 1'b1;
               if (bv != 0) begin
                  if (bv <= 64) begin
                     if (op == 5'd15)      begin c = wide[64 - bv]; wide = wide << bv; end
                     else if (op == 5'd16) begin c = wide[bv - 1];  wide = wide >> bv; end
                     else                  begin c = wide[bv - 1];  wide = $signed(wide) >>> bv; end
                  end else begin
                     c    = (op == 5'd17) ? ahv[31] : 1'b0;
                     wide = (op == 5'd17) ? {64{ahv[31]}} : 64'd0;
                  end
               end
               {rh, r} = wide;
            end
            default: ;
         endcase
      end
      if (op >= 5'd18) begin
         r = 32'd0; rh = 32'd0; fo = fin;
      end else if (is_long) begin
         fo = {rh[31], v, c, ({rh, r} == 64'd0)};
      end else begin
         fo = {r[31], v, c, (r == 32'd0)};
      end
   endfunction

   // Model of the registered outputs: a valid issue loads a new result,
   // an idle edge only clears the valid indication, reset clears everything.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_res   <= 32'd0;
         m_hi    <= 32'd0;
         m_flags <= 4'd0;
      end else if (in_valid) begin
         model_op(oper, a, a_hi, b, flags_in, t_res, t_hi, t_flags);
         m_valid <= 1'b1;
         m_res   <= t_res;
         m_hi    <= t_hi;
         m_flags <= t_flags;
      end else begin
         m_valid <= 1'b0;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      assert_count++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Single checker: samples on the falling edge, and shortly after a reset
   // rises so that an asynchronous clear is seen before the next clock edge.
   always @(negedge clk or posedge rst) begin
      if (rst) #1;
      cmp("model.out_valid", 32'(out_valid), 32'(m_valid));
      cmp("model.result", result, m_res);
      cmp("model.result_hi", result_hi, m_hi);
      cmp("model.flags_out", 32'(flags_out), 32'(m_flags));
      if (lit_armed) begin
         cmp({lit_name, ".out_valid"}, 32'(out_valid), 32'(lit_valid));
         cmp({lit_name, ".result"}, result, lit_res);
         cmp({lit_name, ".result_hi"}, result_hi, lit_hi);
         cmp({lit_name, ".flags_out"}, 32'(flags_out), 32'(lit_flags));
      end
   end

   task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [31:0] av,
                                input logic [31:0] ahv, input logic [31:0] bv,
                                input logic [3:0] fl);
      in_valid = v;
      oper     = op;
      a        = av;
      a_hi     = ahv;
      b        = bv;
      flags_in = fl;
   endtask

   // Arms literal expectations for the next falling edge, i.e. one rising
   // edge after the stimulus that precedes this call.
   task automatic checkOutput(input string name, input logic v, input logic [31:0] r,
                              input logic [31:0] rh, input logic [3:0] fl);
      lit_name  = name;
      lit_valid = v;
      lit_res   = r;
      lit_hi    = rh;
      lit_flags = fl;
      lit_armed = 1'b1;
      @(negedge clk);
      #2;
      lit_armed = 1'b0;
   endtask

   logic [31:0] rb;

   initial begin
      assert_count = 0;
      fail_count   = 0;
      lit_armed    = 1'b0;
      lit_name     = "";
      rst          = 1'b1;
      applyStimulus(1'b0, ADD, 32'd0, 32'd0, 32'd0, 4'h0);
      @(negedge clk);
      #2;
      checkOutput("reset_state", 1'b0, 32'd0, 32'd0, 4'h0);
      rst = 1'b0;

      applyStimulus(1'b1, ADD, 32'h7FFFFFFF, 32'd0, 32'd1, 4'h0);
      checkOutput("add_overflow", 1'b1, 32'h80000000, 32'd0, 4'hC);
      applyStimulus(1'b1, SUB, 32'd5, 32'd0, 32'd5, 4'h0);
      checkOutput("sub_equal", 1'b1, 32'd0, 32'd0, 4'h3);
      applyStimulus(1'b1, SBC, 32'd0, 32'd0, 32'd0, 4'h0);
      checkOutput("sbc_borrow", 1'b1, 32'hFFFFFFFF, 32'd0, 4'h8);
      applyStimulus(1'b1, ADC, 32'hFFFFFFFF, 32'd0, 32'd0, 4'h2);
      checkOutput("adc_carry_in", 1'b1, 32'd0, 32'd0, 4'h3);
      applyStimulus(1'b1, RSB, 32'd1, 32'd0, 32'd0, 4'h0);
      checkOutput("rsb_borrow", 1'b1, 32'hFFFFFFFF, 32'd0, 4'h8);
      applyStimulus(1'b1, LLSL, 32'h80000000, 32'h00000001, 32'd1, 4'h0);
      checkOutput("llsl_by1", 1'b1, 32'd0, 32'h00000003, 4'h0);
      applyStimulus(1'b1, LLSL, 32'h80000000, 32'h00000001, 32'd64, 4'h4);
      checkOutput("llsl_by64", 1'b1, 32'd0, 32'd0, 4'h5);
      applyStimulus(1'b1, LASR, 32'd0, 32'h80000000, 32'd63, 4'h0);
      checkOutput("lasr_by63", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h8);
      applyStimulus(1'b1, LASR, 32'd0, 32'h80000000, 32'd0, 4'h2);
      checkOutput("lasr_by0", 1'b1, 32'd0, 32'h80000000, 4'hA);
      applyStimulus(1'b1, MUL, 32'hFFFFFFFF, 32'd0, 32'd2, 4'h6);
      checkOutput("mul_wide", 1'b1, 32'hFFFFFFFE, 32'd1, 4'hE);
      applyStimulus(1'b1, LSL, 32'h80000001, 32'd0, 32'd33, 4'h2);
      checkOutput("lsl_beyond", 1'b1, 32'd0, 32'd0, 4'h1);
      applyStimulus(1'b1, ASR, 32'h80000000, 32'd0, 32'd40, 4'h0);
      checkOutput("asr_beyond", 1'b1, 32'hFFFFFFFF, 32'd0, 4'hA);
      applyStimulus(1'b1, LSR, 32'h80000001, 32'd0, 32'd1, 4'h0);
      checkOutput("lsr_by1", 1'b1, 32'h40000000, 32'd0, 4'h2);
      applyStimulus(1'b1, ROL, 32'h80000000, 32'd0, 32'd1, 4'h0);
      checkOutput("rol_by1", 1'b1, 32'd1, 32'd0, 4'h2);
      applyStimulus(1'b1, ROR, 32'd1, 32'd0, 32'd1, 4'h0);
      checkOutput("ror_by1", 1'b1, 32'h80000000, 32'd0, 4'hA);
      applyStimulus(1'b0, ADD, 32'd7, 32'd0, 32'd7, 4'h0);
      checkOutput("idle_hold", 1'b0, 32'h80000000, 32'd0, 4'hA);
      applyStimulus(1'b1, 5'd20, 32'h1234, 32'h55, 32'd5, 4'hB);
      checkOutput("reserved_op", 1'b1, 32'd0, 32'd0, 4'hB);
      applyStimulus(1'b1, ANDO, 32'hFFFF0000, 32'd0, 32'h0F0F0F0F, 4'h6);
      checkOutput("and_keep_cv", 1'b1, 32'h0F0F0000, 32'd0, 4'h6);

      // Mid-cycle asynchronous reset while an ADD is being issued
      applyStimulus(1'b1, ADD, 32'd1, 32'd0, 32'd2, 4'h0);
      #1;
      lit_name  = "async_reset";
      lit_valid = 1'b0;
      lit_res   = 32'd0;
      lit_hi    = 32'd0;
      lit_flags = 4'h0;
      lit_armed = 1'b1;
      rst       = 1'b1;
      #2;
      lit_armed = 1'b0;
      @(negedge clk);
      #2;
      applyStimulus(1'b0, ADD, 32'd1, 32'd0, 32'd2, 4'h0);
      rst = 1'b0;
      checkOutput("idle_after_reset", 1'b0, 32'd0, 32'd0, 4'h0);
      applyStimulus(1'b1, ADD, 32'd1, 32'd0, 32'd2, 4'h0);
      checkOutput("first_after_reset", 1'b1, 32'd3, 32'd0, 4'h0);

      // Sweep every opcode over several operand sets, model-checked only
      for (int s = 0; s < 7; s++) begin
         for (int op = 0; op < 32; op++) begin
            case (s)
               0: applyStimulus(1'b1, 5'(op), 32'h12345678, 32'h9ABCDEF0, 32'd3,   4'h2);
               1: applyStimulus(1'b1, 5'(op), 32'h80000000, 32'hFFFFFFFF, 32'd33,  4'h5);
               2: applyStimulus(1'b1, 5'(op), 32'hFFFFFFFF, 32'h00000001, 32'd0,   4'hA);
               3: applyStimulus(1'b1, 5'(op), 32'h7FFFFFFF, 32'h80000000, 32'd63,  4'h0);
               4: applyStimulus(1'b1, 5'(op), 32'h80000001, 32'hC0000000, 32'd100, 4'hF);
               default: begin
                  rb = $urandom_range(0, 70);
                  if (rb == 32'd32 || rb == 32'd64) rb = rb + 32'd1;
                  applyStimulus(1'b1, 5'(op), $urandom, $urandom, rb, 4'($urandom_range(0, 15)));
               end
            endcase
            if (op % 7 == 6) in_valid = 1'b0;
            @(negedge clk);
            #2;
         end
      end

      applyStimulus(1'b0, ADD, 32'd0, 32'd0, 32'd0, 4'h0);
      repeat (3) @(negedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
